// File: rtl/trace_pkg.sv
// Shared types for the lockstep trace checker: checker states and the sticky error-flag bundle.
package trace_pkg;

    localparam int DEF_TRACE_W = 36;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FAIL  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic mismatch;
        logic length_err;
        logic overflow;
        logic timeout;
    } err_flags_t;

    // Sticky accumulation: once a flag is raised it stays raised until reset/clear.
    function automatic err_flags_t merge_flags(input err_flags_t held, input err_flags_t fresh);
        return err_flags_t'(held | fresh);
    endfunction

endpackage

// File: rtl/trace_skew_fifo.sv
// Skew-absorbing FIFO for one trace stream; pointers carry an extra wrap bit to tell full from empty.
module trace_skew_fifo
    import trace_pkg::*;
#(
    parameter int W     = DEF_TRACE_W,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trace_lockstep_checker.sv
// Compares reference and optimised-core instruction traces in order and reports the first divergence,
// overflow, stall timeout or length difference.
module trace_lockstep_checker
    import trace_pkg::*;
#(
    parameter int TRACE_W     = DEF_TRACE_W,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ref_valid,
    input  logic [TRACE_W-1:0] ref_data,
    input  logic               dut_valid,
    input  logic [TRACE_W-1:0] dut_data,
    input  logic               ref_trap,
    input  logic               dut_trap,
    input  logic               clear,
    output logic [CNT_W-1:0]   match_count,
    output logic               mismatch,
    output logic               length_err,
    output logic               overflow,
    output logic               timeout,
    output logic [CNT_W-1:0]   mismatch_idx,
    output logic [TRACE_W-1:0] mismatch_ref,
    output logic [TRACE_W-1:0] mismatch_dut,
    output logic               done,
    output logic               pass
);
    localparam int            SW         = $clog2(STALL_LIMIT) + 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    state_e             state_q, state_d;
    err_flags_t         err_q, err_d, new_err;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [TRACE_W-1:0] cap_ref_q, cap_ref_d;
    logic [TRACE_W-1:0] cap_dut_q, cap_dut_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic               ref_trap_q, ref_trap_d;
    logic               dut_trap_q, dut_trap_d;

    logic               active;
    logic               cmp_go;
    logic               heads_eq;
    logic               one_ne;
    logic               ref_push, dut_push;
    logic               ref_ovf, dut_ovf;
    logic               data_err, stall_hit, len_err, any_err;
    logic [TRACE_W-1:0] ref_head, dut_head;
    logic               ref_full, ref_empty;
    logic               dut_full, dut_empty;

    trace_skew_fifo #(.W(TRACE_W), .DEPTH(DEPTH)) u_ref_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (clear),
        .push   (ref_push),
        .pop    (cmp_go),
        .wdata  (ref_data),
        .head   (ref_head),
        .full   (ref_full),
        .empty  (ref_empty)
    );

    trace_skew_fifo #(.W(TRACE_W), .DEPTH(DEPTH)) u_dut_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (clear),
        .push   (dut_push),
        .pop    (cmp_go),
        .wdata  (dut_data),
        .head   (dut_head),
        .full   (dut_full),
        .empty  (dut_empty)
    );

    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cmp_go   = active && !ref_empty && !dut_empty;
    assign heads_eq = (ref_head == dut_head);
    assign one_ne   = (ref_empty != dut_empty);

    assign ref_push = active && ref_valid && (!ref_full || cmp_go);
    assign dut_push = active && dut_valid && (!dut_full || cmp_go);
    assign ref_ovf  = active && ref_valid && ref_full && !cmp_go;
    assign dut_ovf  = active && dut_valid && dut_full && !cmp_go;

    assign data_err  = cmp_go && !heads_eq;
    assign stall_hit = active && one_ne && (stall_q == STALL_LAST);
    // After both traps, a lone non-empty side with nothing arriving on the other can never be matched.
    assign len_err   = (state_q == ST_DRAIN) &&
                       ((!ref_empty && dut_empty && !dut_valid) ||
                        (ref_empty && !dut_empty && !ref_valid));

    always_comb begin
        new_err            = '0;
        new_err.mismatch   = data_err || len_err;
        new_err.length_err = len_err;
        new_err.overflow   = ref_ovf || dut_ovf;
        new_err.timeout    = stall_hit;
        any_err            = |new_err;
        err_d              = merge_flags(err_q, new_err);

        match_d = match_q;
        if (cmp_go && heads_eq && !(&match_q)) match_d = match_q + CNT_W'(1);

        stall_d = '0;
        if (active && one_ne) stall_d = stall_q + SW'(1);

        idx_d     = idx_q;
        cap_ref_d = cap_ref_q;
        cap_dut_d = cap_dut_q;
        if (any_err) begin
            idx_d     = match_q;
            cap_ref_d = ref_empty ? '0 : ref_head;
            cap_dut_d = dut_empty ? '0 : dut_head;
        end

        ref_trap_d = ref_trap_q || ref_trap;
        dut_trap_d = dut_trap_q || dut_trap;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (any_err)                      state_d = ST_FAIL;
                else if (ref_trap_q && dut_trap_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (any_err)
                    state_d = ST_FAIL;
                else if (ref_empty && dut_empty && !ref_push && !dut_push)
                    state_d = ST_DONE;
            end
            ST_FAIL: state_d = ST_FAIL;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            err_q      <= '0;
            match_q    <= '0;
            idx_q      <= '0;
            cap_ref_q  <= '0;
            cap_dut_q  <= '0;
            stall_q    <= '0;
            ref_trap_q <= 1'b0;
            dut_trap_q <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_RUN;
            err_q      <= '0;
            match_q    <= '0;
            idx_q      <= '0;
            cap_ref_q  <= '0;
            cap_dut_q  <= '0;
            stall_q    <= '0;
            ref_trap_q <= 1'b0;
            dut_trap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            match_q    <= match_d;
            idx_q      <= idx_d;
            cap_ref_q  <= cap_ref_d;
            cap_dut_q  <= cap_dut_d;
            stall_q    <= stall_d;
            ref_trap_q <= ref_trap_d;
            dut_trap_q <= dut_trap_d;
        end
    end

    assign match_count  = match_q;
    assign mismatch     = err_q.mismatch;
    assign length_err   = err_q.length_err;
    assign overflow     = err_q.overflow;
    assign timeout      = err_q.timeout;
    assign mismatch_idx = idx_q;
    assign mismatch_ref = cap_ref_q;
    assign mismatch_dut = cap_dut_q;
    assign done         = (state_q == ST_FAIL) || (state_q == ST_DONE);
    assign pass         = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Directed bench for trace_lockstep_checker with a match-count scoreboard.
module tb_trace_lockstep_checker;
    localparam int TRACE_W = 36;
    localparam int CNT_W   = 32;

    logic               clk;
    logic               resetn;
    logic               ref_valid, dut_valid, ref_trap, dut_trap, clear;
    logic [TRACE_W-1:0] ref_data, dut_data;
    logic [CNT_W-1:0]   match_count, mismatch_idx;
    logic               mismatch, length_err, overflow, timeout, done, pass;
    logic [TRACE_W-1:0] mismatch_ref, mismatch_dut;

    logic               o_ref_valid;
    logic [TRACE_W-1:0] o_ref_data;
    logic               o_zero;
    logic [TRACE_W-1:0] o_zero_data;
    logic [CNT_W-1:0]   o_match_count, o_mismatch_idx;
    logic               o_mismatch, o_length_err, o_overflow, o_timeout, o_done, o_pass;
    logic [TRACE_W-1:0] o_mismatch_ref, o_mismatch_dut;

    int                 passed;
    int                 total;
    int unsigned        exp_q[$];
    logic [CNT_W-1:0]   prev_cnt;

    trace_lockstep_checker #(
        .TRACE_W(TRACE_W), .DEPTH(16), .CNT_W(CNT_W), .STALL_LIMIT(8)
    ) u_dut (
        .clk(clk), .resetn(resetn),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .dut_valid(dut_valid), .dut_data(dut_data),
        .ref_trap(ref_trap), .dut_trap(dut_trap), .clear(clear),
        .match_count(match_count), .mismatch(mismatch), .length_err(length_err),
        .overflow(overflow), .timeout(timeout), .mismatch_idx(mismatch_idx),
        .mismatch_ref(mismatch_ref), .mismatch_dut(mismatch_dut),
        .done(done), .pass(pass)
    );

    // Second instance with a long stall limit so the overflow case is not pre-empted by a timeout.
    trace_lockstep_checker #(
        .TRACE_W(TRACE_W), .DEPTH(16), .CNT_W(CNT_W), .STALL_LIMIT(64)
    ) u_ovf (
        .clk(clk), .resetn(resetn),
        .ref_valid(o_ref_valid), .ref_data(o_ref_data),
        .dut_valid(o_zero), .dut_data(o_zero_data),
        .ref_trap(o_zero), .dut_trap(o_zero), .clear(o_zero),
        .match_count(o_match_count), .mismatch(o_mismatch), .length_err(o_length_err),
        .overflow(o_overflow), .timeout(o_timeout), .mismatch_idx(o_mismatch_idx),
        .mismatch_ref(o_mismatch_ref), .mismatch_dut(o_mismatch_dut),
        .done(o_done), .pass(o_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the edge; every match_count step is scored.
    task automatic step();
        @(posedge clk);
        #1;
        if (match_count !== prev_cnt) begin
            if (match_count != '0) begin
                if (exp_q.size() == 0) check("sb_unexpected_count", 64'(match_count), 64'(prev_cnt));
                else check("sb_count", 64'(match_count), 64'(exp_q.pop_front()));
            end
            prev_cnt = match_count;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"}, 64'(match_count), 64'd0);
        check({tag, "_flags"}, {60'd0, mismatch, length_err, overflow, timeout}, 64'd0);
        check({tag, "_idx"}, 64'(mismatch_idx), 64'd0);
        check({tag, "_cap"}, 64'(mismatch_ref | mismatch_dut), 64'd0);
        check({tag, "_done_pass"}, {62'd0, done, pass}, 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_q.delete();
        prev_cnt = '0;
    endtask

    task automatic pulse_traps();
        ref_trap = 1'b1;
        dut_trap = 1'b1;
        step();
        ref_trap = 1'b0;
        dut_trap = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int i = 0;
        while (!done && i < limit) begin
            step();
            i++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    // Drive ref words 1..n_ref from cycle 0 and dut words 1..n_dut starting at cycle skew;
    // dut word bad_idx (zero-based) is replaced by 0x15. Expected counts are queued as words are driven.
    task automatic run_stream(input int n_ref, input int n_dut, input int skew, input int bad_idx);
        int len = (n_ref > n_dut + skew) ? n_ref : n_dut + skew;
        int expc = int'(match_count);
        bit diverged = 1'b0;
        for (int c = 0; c < len; c++) begin
            ref_valid = (c < n_ref);
            ref_data  = TRACE_W'(c + 1);
            dut_valid = (c >= skew) && (c - skew < n_dut);
            dut_data  = (c - skew == bad_idx) ? TRACE_W'(36'h15) : TRACE_W'(c - skew + 1);
            if (dut_valid && (c - skew < n_ref) && !diverged) begin
                if (c - skew == bad_idx) diverged = 1'b1;
                else begin
                    expc++;
                    exp_q.push_back(expc);
                end
            end
            step();
        end
        ref_valid = 1'b0;
        dut_valid = 1'b0;
    endtask

    initial begin
        passed = 0; total = 0; prev_cnt = '0;
        resetn = 1'b0; clear = 1'b0; ref_trap = 1'b0; dut_trap = 1'b0;
        ref_valid = 1'b0; dut_valid = 1'b0; ref_data = '0; dut_data = '0;
        o_ref_valid = 1'b0; o_ref_data = '0; o_zero = 1'b0; o_zero_data = '0;
        step();
        step();
        check_idle("reset");
        resetn = 1'b1;
        step();

        // Case 1: dut trails ref by 3 cycles, identical streams.
        run_stream(10, 10, 3, -1);
        pulse_traps();
        wait_done(20, "c1_done");
        check("c1_pass", 64'(pass), 64'd1);
        check("c1_count", 64'(match_count), 64'd10);
        check("c1_mismatch", 64'(mismatch), 64'd0);
        check("c1_sb_drained", 64'(exp_q.size()), 64'd0);

        // Case 2: fifth dut word diverges.
        do_clear();
        check_idle("clear_after_pass");
        run_stream(10, 10, 3, 4);
        wait_done(10, "c2_done");
        check("c2_mismatch", 64'(mismatch), 64'd1);
        check("c2_idx", 64'(mismatch_idx), 64'd4);
        check("c2_ref", 64'(mismatch_ref), 64'h5);
        check("c2_dut", 64'(mismatch_dut), 64'h15);
        check("c2_pass", 64'(pass), 64'd0);
        check("c2_count", 64'(match_count), 64'd4);
        check("c2_sb_drained", 64'(exp_q.size()), 64'd0);

        // Case 4: a lone ref word times out after exactly 8 cycles.
        do_clear();
        check_idle("clear_after_fail");
        ref_valid = 1'b1;
        ref_data  = TRACE_W'(36'h7);
        step();
        ref_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("c4_no_early_timeout", 64'(timeout), 64'd0);
        step();
        check("c4_timeout", 64'(timeout), 64'd1);
        check("c4_done", {62'd0, done, pass}, 64'd2);
        check("c4_ref", 64'(mismatch_ref), 64'h7);
        check("c4_dut", 64'(mismatch_dut), 64'd0);

        // Case 5: ref has one word more than dut at end of run.
        do_clear();
        run_stream(4, 3, 0, -1);
        pulse_traps();
        wait_done(10, "c5_done");
        check("c5_length_err", 64'(length_err), 64'd1);
        check("c5_mismatch", 64'(mismatch), 64'd1);
        check("c5_idx", 64'(mismatch_idx), 64'd3);
        check("c5_ref", 64'(mismatch_ref), 64'h4);
        check("c5_dut", 64'(mismatch_dut), 64'd0);
        check("c5_timeout", 64'(timeout), 64'd0);
        check("c5_pass", 64'(pass), 64'd0);

        // Case 3: 17 ref pushes into a 16-deep FIFO with dut silent.
        for (int i = 0; i < 17; i++) begin
            o_ref_valid = 1'b1;
            o_ref_data  = TRACE_W'(i + 1);
            step();
            if (i == 15) check("c3_no_early_overflow", 64'(o_overflow), 64'd0);
        end
        o_ref_valid = 1'b0;
        check("c3_overflow", 64'(o_overflow), 64'd1);
        check("c3_fail", {62'd0, o_done, o_pass}, 64'd2);
        check("c3_timeout", 64'(o_timeout), 64'd0);
        check("c3_fifo_full", 64'(u_ovf.u_ref_fifo.full), 64'd1);
        check("c3_head", 64'(o_mismatch_ref), 64'h1);

        // Case 6: asynchronous reset in the middle of a run, then a clean run.
        do_clear();
        for (int c = 0; c < 5; c++) begin
            ref_valid = 1'b1; ref_data = TRACE_W'(c + 1);
            dut_valid = 1'b1; dut_data = TRACE_W'(c + 1);
            exp_q.push_back(c + 1);
            step();
        end
        check("c6_progress", 64'(match_count), 64'd4);
        resetn = 1'b0;
        ref_valid = 1'b0; dut_valid = 1'b0;
        #1;
        check_idle("c6_async_reset");
        exp_q.delete();
        prev_cnt = '0;
        step();
        resetn = 1'b1;
        step();
        check("c6_ovf_inst_reset", 64'(o_overflow), 64'd0);
        run_stream(10, 10, 3, -1);
        pulse_traps();
        wait_done(20, "c6_done");
        check("c6_pass", 64'(pass), 64'd1);
        check("c6_count", 64'(match_count), 64'd10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
